fir_decim_sequencer: RTL and testbench

Controller for a single shared multiply-accumulate that implements a decimating FIR filter in the FM radio fixed-point datapath. Samples are Q10 (BITS = 10).
- Reads DECIM samples from an upstream first-word-fall-through FIFO into a circular sample buffer.
- Sequences NUM_TAPS MAC cycles against an external coefficient ROM.
- Writes one dequantized result to the downstream FIFO.
- Sits between the demodulator output and the audio sink; with defaults it reduces QUAD_RATE (256 kS/s) to AUDIO_RATE (32 kS/s).

---
 rtl/fir_decim_sequencer_if.sv | 28 ++
 rtl/fir_decim_sequencer.sv | 159 +++++++++++++++
 tb/tb_fir_decim_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_sequencer_if.sv
// Handshake bundle for fir_decim_sequencer: upstream FIFO pop,
// coefficient ROM read, downstream FIFO push and busy flag.
interface fir_decim_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_TAPS = 32
);
    localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    logic signed [DATA_W-1:0] in_dout;
    logic                     in_empty;
    logic                     in_rd_en;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [DATA_W-1:0] coef_data;
    logic signed [DATA_W-1:0] out_din;
    logic                     out_full;
    logic                     out_wr_en;
    logic                     busy;

    modport master (
        input  in_dout, in_empty, coef_data, out_full,
        output in_rd_en, coef_addr, out_din, out_wr_en, busy
    );

    modport slave (
        output in_dout, in_empty, coef_data, out_full,
        input  in_rd_en, coef_addr, out_din, out_wr_en, busy
    );
endinterface

// File: rtl/fir_decim_sequencer.sv
// fir_decim_sequencer: decimating FIR controller around one shared MAC.
// Pops DECIM samples into a circular buffer, runs NUM_TAPS MAC cycles
// against an external coefficient ROM, then pushes one result.
// Ports: clock, reset_n (synchronous, active-low),
//   bus (fir_decim_sequencer_if.master):
//     in_dout/in_empty/in_rd_en   upstream first-word-fall-through FIFO
//     coef_addr/coef_data         coefficient ROM, data 1 cycle after addr
//     out_din/out_full/out_wr_en  downstream FIFO
//     busy                        high while computing or writing
// Option macro FIR_SAT_EN: saturate every accumulate step
//   (undefined: accumulator wraps modulo 2^DATA_W).
module fir_decim_sequencer #(
    parameter int DECIM    = 8,
    parameter int NUM_TAPS = 32,
    parameter int BITS     = 10,
    parameter int DATA_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    fir_decim_sequencer_if.master        bus
);
    localparam int ADDR_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int FILL_W = $clog2(DECIM + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_MAC,
        S_WRITE
    } state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_buf [NUM_TAPS];
    logic        [ADDR_W-1:0] r_wr_ptr;
    logic        [ADDR_W-1:0] r_rd_ptr;
    logic        [FILL_W-1:0] r_fill_cnt;
    logic        [CNT_W-1:0]  r_tap_idx;
    logic        [ADDR_W-1:0] r_coef_addr;
    logic signed [DATA_W-1:0] r_pipe;
    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] r_out_din;
    logic                     r_busy;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0]   w_deq;
    logic signed [DATA_W-1:0]   w_acc_next;
    logic        [ADDR_W-1:0]   w_wr_inc;
    logic        [ADDR_W-1:0]   w_rd_dec;
    logic                       w_pop;
    logic                       w_push;

    // Full-width product, arithmetic shift by BITS, truncate to DATA_W.
    assign w_prod = (2*DATA_W)'(bus.coef_data) * (2*DATA_W)'(r_pipe);
    assign w_deq  = DATA_W'(w_prod >>> BITS);

`ifdef FIR_SAT_EN
    logic signed [DATA_W:0] w_sum;

    assign w_sum = (DATA_W+1)'(r_acc) + (DATA_W+1)'(w_deq);

    // Top two bits disagree only on overflow; the sign bit picks the rail.
    always_comb begin
        w_acc_next = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
            w_acc_next = w_sum[DATA_W]
                       ? {1'b1, {(DATA_W-1){1'b0}}}
                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_next = r_acc + w_deq;
`endif

    assign w_wr_inc = (r_wr_ptr == ADDR_W'(NUM_TAPS - 1))
                    ? '0 : r_wr_ptr + ADDR_W'(1);
    assign w_rd_dec = (r_rd_ptr == '0)
                    ? ADDR_W'(NUM_TAPS - 1) : r_rd_ptr - ADDR_W'(1);

    // Gated by reset_n so nothing is popped or pushed while held in reset.
    assign w_pop  = reset_n && (r_state == S_FILL) && !bus.in_empty;
    assign w_push = reset_n && (r_state == S_WRITE) && !bus.out_full;

    assign bus.in_rd_en  = w_pop;
    assign bus.out_wr_en = w_push;
    assign bus.out_din   = r_out_din;
    assign bus.coef_addr = r_coef_addr;
    assign bus.busy      = r_busy;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_tap_idx   <= '0;
            r_coef_addr <= '0;
            r_pipe      <= '0;
            r_acc       <= '0;
            r_out_din   <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (!bus.in_empty) begin
                        r_buf[r_wr_ptr] <= bus.in_dout;
                        r_wr_ptr        <= w_wr_inc;
                        if (r_fill_cnt == FILL_W'(DECIM - 1)) begin
                            r_fill_cnt  <= '0;
                            r_acc       <= '0;
                            // Slot just written is tap 0.
                            r_rd_ptr    <= r_wr_ptr;
                            r_tap_idx   <= '0;
                            r_coef_addr <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_MAC;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    // Fetch side: tap sample lines up with the ROM's
                    // one-cycle read latency.
                    if (r_tap_idx != CNT_W'(NUM_TAPS)) begin
                        r_pipe   <= r_buf[r_rd_ptr];
                        r_rd_ptr <= w_rd_dec;
                        if (r_tap_idx == CNT_W'(NUM_TAPS - 1)) begin
                            r_coef_addr <= '0;
                        end else begin
                            r_coef_addr <= r_coef_addr + ADDR_W'(1);
                        end
                    end
                    // Accumulate side lags the fetch side by one cycle.
                    if (r_tap_idx != '0) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_tap_idx == CNT_W'(NUM_TAPS)) begin
                        r_out_din <= w_acc_next;
                        r_state   <= S_WRITE;
                    end else begin
                        r_tap_idx <= r_tap_idx + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!bus.out_full) begin
                        r_busy  <= 1'b0;
                        r_state <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_decim_sequencer.sv
// Bench for fir_decim_sequencer: FIFO/ROM models, a sum-of-products
// reference model, directed scenarios and randomized traffic.
module tb_fir_decim_sequencer;
    localparam int DECIM    = 8;
    localparam int NUM_TAPS = 32;
    localparam int BITS     = 10;
    localparam int DATA_W   = 32;

    logic clock;
    logic reset_n;

    fir_decim_sequencer_if #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) bus ();

    fir_decim_sequencer #(
        .DECIM(DECIM), .NUM_TAPS(NUM_TAPS), .BITS(BITS), .DATA_W(DATA_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int coef [NUM_TAPS];
    int src_q[$];
    int hist[$];
    int got_q[$];
    int push_cyc[$];
    int pop_cyc[$];
    int n_out, cyc;
    int n_chk, n_pass;
    bit stall, full_drv, rand_mode, bp_mode, popped;

    // Coefficient ROM with one cycle of read latency.
    always @(posedge clock) bus.coef_data <= coef[bus.coef_addr];

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // y = sum over taps of DEQ(c[k] * x[newest-k]); unwritten taps are 0.
    function automatic int model_y();
        int acc = 0;
        int p = hist.size();
        for (int k = 0; k < NUM_TAPS; k++) begin
            int idx = p - 1 - k;
            int x = (idx >= 0) ? hist[idx] : 0;
            longint prod = longint'(coef[k]) * longint'(x);
            int d = int'(prod >>> BITS);
`ifdef FIR_SAT_EN
            longint s = longint'(acc) + longint'(d);
            if (s > 64'sd2147483647) acc = int'(32'h7FFFFFFF);
            else if (s < -64'sd2147483648) acc = int'(32'h80000000);
            else acc = int'(s);
`else
            acc = acc + d;
`endif
        end
        return acc;
    endfunction

    // Compare process: tracks pops, checks every push and stall cycle.
    always @(negedge clock) begin : cmp
        cyc++;
        if (!reset_n) begin
            hist.delete();
            pop_cyc.delete();
            n_out = 0;
            popped = 0;
        end else begin
            popped = bus.in_rd_en;
            if (bus.in_rd_en) begin
                chk("pop_while_empty", bus.in_empty, 0);
                chk("pop_while_busy", bus.busy, 0);
                hist.push_back(int'(bus.in_dout));
                pop_cyc.push_back(cyc);
            end
            if (bus.out_wr_en) begin
                n_out++;
                chk("push_while_full", bus.out_full, 0);
                chk("pops_per_output", hist.size(), n_out * DECIM);
                chk($sformatf("out_din#%0d", n_out),
                    bus.out_din, model_y());
                got_q.push_back(int'(bus.out_din));
                push_cyc.push_back(cyc);
            end
            if (bp_mode) begin
                chk("bp_wr_en", bus.out_wr_en, 0);
                chk("bp_rd_en", bus.in_rd_en, 0);
                chk("bp_out_din", bus.out_din, model_y());
            end
        end
    end

    task automatic drive();
        if (rand_mode) begin
            stall    = ($urandom_range(0, 3) == 0);
            full_drv = ($urandom_range(0, 2) == 0);
        end
        bus.in_empty = stall || (src_q.size() == 0);
        bus.in_dout  = (src_q.size() != 0) ? src_q[0] : 0;
        bus.out_full = full_drv;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (popped && src_q.size() != 0) void'(src_q.pop_front());
        popped = 0;
        drive();
    endtask

    task automatic reset_dut();
        rand_mode = 0;
        stall = 0;
        full_drv = 0;
        bp_mode = 0;
        src_q.delete();
        reset_n = 1'b0;
        drive();
        tick();
        tick();
        reset_n = 1'b1;
        got_q.delete();
        push_cyc.delete();
        drive();
    endtask

    task automatic wait_out(int n, int budget, string name);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_outputs_seen"}, got_q.size() >= n, 1);
    endtask

    task automatic wait_busy(int budget);
        int c = 0;
        while (!bus.busy && c < budget) begin
            tick();
            c++;
        end
        chk("busy_reached", bus.busy, 1);
    endtask

    function automatic int got(int i);
        return (i < got_q.size()) ? got_q[i] : -1;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int exp_const[6] = '{32'h2000, 32'h4000, 32'h6000,
                         32'h8000, 32'h8000, 32'h8000};
    int exp_imp[6]   = '{32'h2000, 32'h4000, 32'h6000,
                         32'h8000, 0, 0};

    initial begin
        int sat_exp;
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        stall = 0;
        full_drv = 0;
        rand_mode = 0;
        bp_mode = 0;
        popped = 0;
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 0;

        // Reset values, with data waiting upstream.
        reset_n = 1'b0;
        src_q.push_back(32'h123);
        drive();
        tick();
        tick();
        chk("rst_in_rd_en", bus.in_rd_en, 0);
        chk("rst_out_wr_en", bus.out_wr_en, 0);
        chk("rst_out_din", bus.out_din, 0);
        chk("rst_coef_addr", bus.coef_addr, 0);
        chk("rst_busy", bus.busy, 0);

        // Constant input, unity coefficients.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 32'h400;
        for (int i = 0; i < 6 * DECIM; i++) src_q.push_back(32'h400);
        drive();
        wait_out(6, 600, "const");
        for (int i = 0; i < 6; i++)
            chk($sformatf("const_y%0d", i + 1), got(i), exp_const[i]);
        chk("frame_period",
            (push_cyc.size() >= 3) ? push_cyc[2] - push_cyc[1] : -1, 42);
        chk("pop_to_push_latency",
            (push_cyc.size() >= 1 && pop_cyc.size() >= DECIM)
                ? push_cyc[0] - pop_cyc[DECIM-1] : -1,
            NUM_TAPS + 2);

        // Impulse against a ramp of coefficients.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = (k + 1) << 10;
        src_q.push_back(32'h400);
        for (int i = 1; i < 6 * DECIM; i++) src_q.push_back(0);
        drive();
        wait_out(6, 600, "impulse");
        for (int i = 0; i < 6; i++)
            chk($sformatf("imp_y%0d", i + 1), got(i), exp_imp[i]);

        // Backpressure: downstream full well into the write state.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 32'h400;
        for (int i = 0; i < 2 * DECIM; i++) src_q.push_back(32'h400);
        full_drv = 1;
        drive();
        wait_busy(100);
        repeat (40) tick();
        bp_mode = 1;
        repeat (20) tick();
        bp_mode = 0;
        chk("bp_no_output", got_q.size(), 0);
        full_drv = 0;
        drive();
        @(negedge clock);
        chk("push_on_release", bus.out_wr_en, 1);
        wait_out(2, 200, "bp");
        chk("bp_y1", got(0), 32'h2000);
        chk("bp_y2", got(1), 32'h4000);

        // Upstream empty for 10 cycles after the 3rd pop.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 32'h400;
        for (int i = 0; i < DECIM; i++) src_q.push_back(32'h400);
        drive();
        begin
            int c = 0;
            while (hist.size() < 3 && c < 50) begin
                tick();
                c++;
            end
        end
        stall = 1;
        drive();
        repeat (10) tick();
        chk("no_pop_in_stall", hist.size(), 3);
        stall = 0;
        drive();
        wait_out(1, 200, "stall");
        chk("stall_y1", got(0), 32'h2000);

        // Reset in the middle of the MAC sweep.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 32'h400;
        for (int i = 0; i < 2 * DECIM; i++) src_q.push_back(32'h400);
        drive();
        wait_busy(100);
        repeat (10) tick();
        chk("coef_addr_tap10", bus.coef_addr, 10);
        reset_n = 1'b0;
        drive();
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_out_din", bus.out_din, 0);
        chk("midrst_coef_addr", bus.coef_addr, 0);
        chk("midrst_wr_en", bus.out_wr_en, 0);
        chk("midrst_rd_en", bus.in_rd_en, 0);
        reset_n = 1'b1;
        drive();
        wait_out(1, 200, "midrst");
        chk("midrst_y1", got(0), 32'h2000);
        chk("midrst_no_partial", got_q.size(), 1);

        // Large samples: the sum overflows the accumulator.
        reset_dut();
        for (int k = 0; k < NUM_TAPS; k++) coef[k] = 32'h400;
        for (int i = 0; i < DECIM; i++) src_q.push_back(32'h40000000);
        drive();
        wait_out(1, 200, "sat");
`ifdef FIR_SAT_EN
        sat_exp = int'(32'h7FFFFFFF);
`else
        sat_exp = 0;
`endif
        chk("sat_y1", got(0), sat_exp);

        // Randomized traffic with random stalls on both sides.
        for (int r = 0; r < 3; r++) begin
            reset_dut();
            for (int k = 0; k < NUM_TAPS; k++)
                coef[k] = (r == 0) ? int'($urandom_range(0, 4095)) - 2048
                                   : int'($urandom);
            for (int i = 0; i < 10 * DECIM; i++)
                src_q.push_back((r == 0)
                    ? int'($urandom_range(0, 65535)) - 32768
                    : int'($urandom));
            rand_mode = 1;
            drive();
            wait_out(10, 3000, $sformatf("rand%0d", r));
            rand_mode = 0;
            stall = 0;
            full_drv = 0;
            drive();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
